oam_dma: RTL and testbench

- Sprite DMA engine mapped at CPU address $4014; CPU chip-select decode asserts i_cs_n only for that address.
- A CPU write of page P halts the CPU via RDY, takes over the CPU bus and copies CPU memory $P00-$PFF into the PPU's OAMDATA register ($2004): 256 read/write pairs.
- Sits between the CPU core, the CPU address/data bus and the PPU. It is the upstream feeder of the PPU's OAM.

---
 rtl/oam_dma_pkg.sv | 21 ++
 rtl/oam_dma.sv | 129 ++++++++++++
 tb/tb_oam_dma.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_pkg.sv
// Shared definitions for the sprite DMA engine at $4014: FSM state
// encodings, the OAMDATA target address and the CPU bus read/write levels.
package oam_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  localparam logic [15:0] OAMDATA_ADDR    = 16'h2004;
  localparam int          TRANSFER_LENGTH = 256;
  localparam logic [7:0]  LAST_INDEX      = 8'(TRANSFER_LENGTH - 1);

  // Bus read/~write levels, shared with the CPU core and the PPU.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine. A CPU write to $4014 with page P halts the CPU and
// copies $P00-$PFF into OAMDATA ($2004) as 256 read/write pairs.
//
// Handshake: o_rdy is the CPU's RDY line. It drops on the edge that accepts
// the trigger write and rises again on the edge that completes the final
// OAMDATA write; while it is low the CPU is halted and this block owns the
// bus whenever o_bus_master = 1. No other handshake exists: the trigger is a
// single-cycle write strobe (i_cs_n = 0, i_rw = 0) honoured only in IDLE.
//
// All registers update on the falling edge of i_clk, like the CPU and PPU.
module oam_dma
  import oam_dma_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cs_n,
  input  logic        i_rw,
  input  logic [7:0]  i_data,
  input  logic [7:0]  i_bus_data,
  output logic        o_rdy,
  output logic        o_bus_master,
  output logic [15:0] o_address,
  output logic        o_rw,
  output logic [7:0]  o_data,
  output logic [2:0]  o_debug_state,
  output logic [7:0]  o_debug_page,
  output logic [7:0]  o_debug_index
);

  state_t     r_state;
  logic [7:0] r_page;
  logic [7:0] r_index;
  logic [7:0] r_latch;
  logic       r_parity;
  logic       r_odd_start;
  logic       r_rdy;
  logic       w_trigger;

  // A CPU write to $4014; only acted on while IDLE.
  assign w_trigger = !i_cs_n && (i_rw == RW_WRITE);

  // Free-running cycle parity; 0 marks an even cycle.
  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= ~r_parity;
    end
  end

  // Transfer sequencer: halt, optional alignment cycle, then read/write pairs.
  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_page      <= 8'h00;
      r_index     <= 8'h00;
      r_latch     <= 8'h00;
      r_odd_start <= 1'b0;
      r_rdy       <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_page      <= i_data;
            r_index     <= 8'h00;
            r_odd_start <= r_parity;
            r_rdy       <= 1'b0;
            r_state     <= ST_HALT;
          end
        end
        ST_HALT: begin
          // A trigger on an odd cycle needs one extra cycle so reads land
          // on the same cycle phase as an even-cycle start.
          r_state <= r_odd_start ? ST_ALIGN : ST_READ;
        end
        ST_ALIGN: begin
          r_state <= ST_READ;
        end
        ST_READ: begin
          r_latch <= i_bus_data;
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (r_index == LAST_INDEX) begin
            r_rdy   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_index <= r_index + 8'd1;
            r_state <= ST_READ;
          end
        end
        default: begin
          r_rdy   <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus drive decoded from registered state only; idle values otherwise so
  // the top-level CPU/DMA mux sees clean zeros when the CPU owns the bus.
  always_comb begin
    o_bus_master = 1'b0;
    o_address    = 16'h0000;
    o_rw         = RW_READ;
    o_data       = 8'h00;
    case (r_state)
      ST_READ: begin
        o_bus_master = 1'b1;
        o_address    = {r_page, r_index};
        o_rw         = RW_READ;
      end
      ST_WRITE: begin
        o_bus_master = 1'b1;
        o_address    = OAMDATA_ADDR;
        o_rw         = RW_WRITE;
        o_data       = r_latch;
      end
      default: begin
      end
    endcase
  end

  assign o_rdy         = r_rdy;
  assign o_debug_state = r_state;
  assign o_debug_page  = r_page;
  assign o_debug_index = r_index;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for the $4014 sprite DMA engine. Expected bus traffic is generated
// per transfer from the copy rules (256 x {read $Pii, write $2004 <- mem})
// and consumed by an independent bus monitor.
`timescale 1ns/1ps
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        rw = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  bus_data;
  logic        rdy;
  logic        bus_master;
  logic [15:0] address;
  logic        o_rw;
  logic [7:0]  o_data;
  logic [2:0]  dbg_state;
  logic [7:0]  dbg_page;
  logic [7:0]  dbg_index;

  int checks = 0;
  int failures = 0;

  // Scoreboard: {address, rw, data}
  logic [24:0] exp_q[$];
  int          exp_lat = 0;
  logic        model_busy = 1'b0;
  logic [7:0]  model_page = 8'h00;
  logic [7:0]  seed = 8'h00;
  int          cyc = 0;

  oam_dma dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_cs_n        (cs_n),
    .i_rw          (rw),
    .i_data        (data_in),
    .i_bus_data    (bus_data),
    .o_rdy         (rdy),
    .o_bus_master  (bus_master),
    .o_address     (address),
    .o_rw          (o_rw),
    .o_data        (o_data),
    .o_debug_state (dbg_state),
    .o_debug_page  (dbg_page),
    .o_debug_index (dbg_index)
  );

  // Clock / memory model
  always #5 clk = ~clk;

  // CPU memory contents: byte = low address byte ^ $5A ^ seed.
  always_comb bus_data = address[7:0] ^ 8'h5A ^ seed;

  // Edges since reset release; bit 0 is the parity of the next edge.
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Monitor: compares every bus cycle and the RDY-low duration.
  initial begin : monitor
    int low_cnt;
    logic [24:0] e;
    low_cnt = 0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        low_cnt = 0;
      end else begin
        if (bus_master) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_bus addr=%h rw=%b data=%h expected no bus cycle",
                     address, o_rw, o_data);
          end else begin
            e = exp_q.pop_front();
            if ({address, o_rw, o_data} !== e) begin
              failures++;
              $display("FAIL bus_cycle got addr=%h rw=%b data=%h expected addr=%h rw=%b data=%h",
                       address, o_rw, o_data, e[24:9], e[8], e[7:0]);
            end
          end
        end else begin
          checks++;
          if (address !== 16'h0000 || o_rw !== 1'b1 || o_data !== 8'h00) begin
            failures++;
            $display("FAIL idle_bus got addr=%h rw=%b data=%h expected 0000/1/00",
                     address, o_rw, o_data);
          end
        end
        if (!rdy) begin
          if (!model_busy) begin
            failures++;
            $display("FAIL spurious_halt rdy=0 expected 1 while idle");
          end
          low_cnt++;
        end else if (low_cnt != 0) begin
          checks++;
          if (low_cnt != exp_lat) begin
            failures++;
            $display("FAIL rdy_low_length got %0d expected %0d", low_cnt, exp_lat);
          end
          low_cnt = 0;
          model_busy = 1'b0;
        end
      end
    end
  end

  // Driver tasks
  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  // want_parity: 0/1 forces the trigger edge parity, -1 takes whatever comes.
  task automatic trigger(input logic [7:0] p, input int want_parity);
    int n;
    logic odd;
    @(posedge clk);
    if (want_parity >= 0) begin
      n = 0;
      while (cyc[0] != want_parity[0] && n < 4) begin
        @(posedge clk);
        n++;
      end
    end
    odd = cyc[0];
    cs_n = 1'b0; rw = 1'b0; data_in = p;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({p, 8'(i), 1'b1, 8'h00});
      exp_q.push_back({16'h2004, 1'b0, 8'(i) ^ 8'h5A ^ seed});
    end
    exp_lat = odd ? 514 : 513;
    model_busy = 1'b1;
    model_page = p;
    @(negedge clk);
    #1 cs_n = 1'b1; rw = 1'b1; data_in = 8'($urandom);
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!bus_master && n < 10);
    check_eq("first_read_delay", 32'(n), odd ? 32'd3 : 32'd2);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (model_busy && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (model_busy) begin
      failures++;
      $display("FAIL transfer_timeout rdy=%b expected 1 within 3000 cycles", rdy);
      model_busy = 1'b0;
    end
    repeat (2) @(posedge clk);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check_eq("latched_page", 32'(dbg_page), 32'(model_page));
  endtask

  // Stimulus
  initial begin : stimulus
    int n;
    #23 reset_n = 1'b1;
    @(posedge clk); #1;
    check_eq("reset_rdy", 32'(rdy), 32'd1);
    check_eq("reset_master", 32'(bus_master), 32'd0);
    check_eq("reset_rw", 32'(o_rw), 32'd1);
    check_eq("reset_state", 32'(dbg_state), 32'd0);
    check_eq("reset_page", 32'(dbg_page), 32'd0);
    check_eq("reset_index", 32'(dbg_index), 32'd0);

    // Even and odd trigger edges, page $02, plain pattern.
    seed = 8'h00;
    trigger(8'h02, 0);
    wait_idle();
    trigger(8'h02, 1);
    wait_idle();

    // Second $4014 write mid-transfer is ignored.
    trigger(8'h02, -1);
    repeat (100) @(posedge clk);
    cs_n = 1'b0; rw = 1'b0; data_in = 8'h07;
    @(negedge clk);
    #1 cs_n = 1'b1; rw = 1'b1;
    wait_idle();

    // Top page.
    seed = 8'($urandom);
    trigger(8'hFF, -1);
    wait_idle();

    // Reads of $4014 never trigger.
    repeat (20) begin
      @(posedge clk);
      cs_n = 1'b0; rw = 1'b1; data_in = 8'($urandom);
    end
    @(posedge clk);
    cs_n = 1'b1;
    #1;
    check_eq("read_no_trigger_rdy", 32'(rdy), 32'd1);
    check_eq("read_no_trigger_state", 32'(dbg_state), 32'd0);

    // Reset during READ at index $40, then restart.
    seed = 8'($urandom);
    trigger(8'h02, -1);
    n = 0;
    while (!(dbg_state == 3'd3 && dbg_index == 8'h40) && n < 400) begin
      @(posedge clk);
      n++;
    end
    check_eq("reached_index_40", 32'(dbg_index), 32'h40);
    #2 reset_n = 1'b0;
    #1;
    check_eq("abort_rdy", 32'(rdy), 32'd1);
    check_eq("abort_master", 32'(bus_master), 32'd0);
    check_eq("abort_state", 32'(dbg_state), 32'd0);
    check_eq("abort_index", 32'(dbg_index), 32'd0);
    exp_q.delete();
    model_busy = 1'b0;
    model_page = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    seed = 8'($urandom);
    trigger(8'($urandom), -1);
    wait_idle();

    // Random transfers with random gaps.
    repeat (3) begin
      repeat ($urandom_range(0, 7)) @(posedge clk);
      seed = 8'($urandom);
      trigger(8'($urandom), -1);
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog simulation time limit reached expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
